adbg_core_halt_ctrl: RTL

CPU-side responder for the debug stall protocol: receives the per-core stall level produced by the debug unit's status register and halts each core in an orderly way. It also reports breakpoint and single-step completion back as `bp_o`, which the status register latches into its stall state. The block sits in the CPU clock domain between the debug unit and the cores' pipeline control. Every input is already synchronous to `cpu_clk_i`.

---
 rtl/adbg_halt_pkg.sv | 14 +
 rtl/adbg_core_halt_fsm.sv | 88 ++++++++
 rtl/adbg_core_halt_ctrl.sv | 41 ++++
 3 files changed

// File: rtl/adbg_halt_pkg.sv
// Shared types and default constants for the CPU-side debug halt controller.
package adbg_halt_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } halt_state_e;

    localparam int DEF_DRAIN_TIMEOUT = 255;
    localparam int DEF_CNT_W         = 8;

endpackage : adbg_halt_pkg

// File: rtl/adbg_core_halt_fsm.sv
// One core's halt FSM: orderly drain, confirmed halt, single step, forced halt on drain timeout.
module adbg_core_halt_fsm
    import adbg_halt_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic cpu_clk_i,
    input  logic cpu_rstn_i,
    input  logic stall,
    input  logic step,
    input  logic bp_hit,
    input  logic retire,
    input  logic idle,
    output logic core_halt,
    output logic bp,
    output logic halted,
    output logic timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(DRAIN_TIMEOUT);

    halt_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             bp_nxt, timeout_nxt;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nxt   = state;
        cnt_nxt     = '0;
        bp_nxt      = 1'b0;
        timeout_nxt = timeout;
        unique case (state)
            RUN: begin
                if (bp_hit || stall) begin
                    state_nxt = DRAIN;
                    bp_nxt    = bp_hit;
                end
            end
            DRAIN: begin
                // Idle wins over the timeout when both land on the same cycle.
                if (idle) begin
                    state_nxt = HALTED;
                end else if (cnt == TIMEOUT_VAL) begin
                    state_nxt   = HALTED;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HALTED: begin
                if (!stall) begin
                    state_nxt   = step ? STEP : RUN;
                    timeout_nxt = 1'b0;
                end
            end
            STEP: begin
                if (retire || bp_hit) begin
                    state_nxt = DRAIN;
                    bp_nxt    = 1'b1;
                end else if (stall) begin
                    state_nxt = DRAIN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!cpu_rstn_i) begin
            state   <= RUN;
            cnt     <= '0;
            bp      <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bp      <= bp_nxt;
            timeout <= timeout_nxt;
        end
    end

    // Decoded from the state register, so reset drops the halt request asynchronously.
    assign core_halt = (state == DRAIN) || (state == HALTED);
    assign halted    = (state == HALTED);

endmodule : adbg_core_halt_fsm

// File: rtl/adbg_core_halt_ctrl.sv
// CPU-side responder to the debug stall protocol: one independent halt FSM per core.
module adbg_core_halt_ctrl
    import adbg_halt_pkg::*;
#(
    parameter int NB_CORES      = 4,
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                cpu_clk_i,
    input  logic                cpu_rstn_i,
    input  logic [NB_CORES-1:0] stall_i,
    input  logic [NB_CORES-1:0] step_i,
    input  logic [NB_CORES-1:0] core_bp_hit_i,
    input  logic [NB_CORES-1:0] core_retire_i,
    input  logic [NB_CORES-1:0] core_idle_i,
    output logic [NB_CORES-1:0] core_halt_o,
    output logic [NB_CORES-1:0] bp_o,
    output logic [NB_CORES-1:0] halted_o,
    output logic [NB_CORES-1:0] timeout_o
);

    for (genvar i = 0; i < NB_CORES; i++) begin : g_core
        adbg_core_halt_fsm #(
            .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
            .CNT_W         (CNT_W)
        ) u_fsm (
            .cpu_clk_i  (cpu_clk_i),
            .cpu_rstn_i (cpu_rstn_i),
            .stall      (stall_i[i]),
            .step       (step_i[i]),
            .bp_hit     (core_bp_hit_i[i]),
            .retire     (core_retire_i[i]),
            .idle       (core_idle_i[i]),
            .core_halt  (core_halt_o[i]),
            .bp         (bp_o[i]),
            .halted     (halted_o[i]),
            .timeout    (timeout_o[i])
        );
    end

endmodule : adbg_core_halt_ctrl
